// File: rtl/audio_lock_detect_if.sv
// Bus bundle between the I2S frame-lock detector and its environment.
interface audio_lock_detect_if #(
  parameter int unsigned CNT_W = 12
);
  logic             enable_in;
  logic             ws_in;
  logic             audio_locked_out;
  logic [CNT_W-1:0] period_out;
  logic             frame_strobe_out;

  // Environment side: drives enable and word-select, observes lock status.
  modport master (
    output enable_in, ws_in,
    input  audio_locked_out, period_out, frame_strobe_out
  );

  // Detector side.
  modport slave (
    input  enable_in, ws_in,
    output audio_locked_out, period_out, frame_strobe_out
  );
endinterface

// File: rtl/audio_lock_detect.sv
// I2S frame-rate lock detector: measures ws rising-edge periods in clk_in
// cycles and declares lock after a run of consistent periods.
module audio_lock_detect #(
  parameter int unsigned CNT_W         = 12,
  parameter int unsigned MIN_PERIOD    = 16,
  parameter int unsigned TOL           = 2,
  parameter int unsigned LOCK_FRAMES   = 8,
  parameter int unsigned UNLOCK_MISSES = 2
) (
  input  logic                 clk_in,
  input  logic                 resetb,
  audio_lock_detect_if.slave   bus
);

  localparam int unsigned MC_W = (LOCK_FRAMES   < 1) ? 1 : $clog2(LOCK_FRAMES + 1);
  localparam int unsigned MS_W = (UNLOCK_MISSES < 1) ? 1 : $clog2(UNLOCK_MISSES + 1);
  localparam logic [CNT_W-1:0] TIMEOUT = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_PRIME,
    ST_ACQUIRE,
    ST_LOCKED
  } state_e;

  state_e           state_q, state_d;
  logic             ws_s1_q, ws_s2_q, ws_edge_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] ref_q, ref_d;
  logic [MC_W-1:0]  match_cnt_q, match_cnt_d;
  logic [MS_W-1:0]  miss_cnt_q, miss_cnt_d;
  logic             locked_q, locked_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             strobe_q, strobe_d;

  logic             edge_c;
  logic             timeout_c;
  logic signed [CNT_W:0] diff_c;
  logic [CNT_W:0]   abs_diff_c;
  logic             match_c;

  // Bring asynchronous ws into the clk_in domain and keep one extra stage for edge detection.
  always_ff @(posedge clk_in) begin
    if (!resetb) begin
      ws_s1_q   <= 1'b0;
      ws_s2_q   <= 1'b0;
      ws_edge_q <= 1'b0;
    end else begin
      ws_s1_q   <= bus.ws_in;
      ws_s2_q   <= ws_s1_q;
      ws_edge_q <= ws_s2_q;
    end
  end

  // Measured period is the counter value on the edge cycle; compare it with the reference.
  always_comb begin
    edge_c     = ws_s2_q & ~ws_edge_q;
    timeout_c  = (cnt_q == TIMEOUT);
    diff_c     = $signed({1'b0, cnt_q}) - $signed({1'b0, ref_q});
    abs_diff_c = diff_c[CNT_W] ? (CNT_W+1)'(-diff_c) : (CNT_W+1)'(diff_c);
    match_c    = (cnt_q >= CNT_W'(MIN_PERIOD)) && !timeout_c &&
                 (abs_diff_c <= (CNT_W+1)'(TOL));
  end

  // Next-state, datapath and output decode; disable overrides edge and timeout.
  always_comb begin
    state_d     = state_q;
    ref_d       = ref_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    if (edge_c) begin
      cnt_d = CNT_W'(1);
    end else if (timeout_c) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (!bus.enable_in) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      ref_d       = '0;
      match_cnt_d = '0;
      miss_cnt_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_SEARCH;
        end
        ST_SEARCH: begin
          if (edge_c) state_d = ST_PRIME;
        end
        ST_PRIME: begin
          if (edge_c) begin
            ref_d       = cnt_q;
            match_cnt_d = '0;
            state_d     = ST_ACQUIRE;
          end else if (timeout_c) begin
            state_d     = ST_SEARCH;
            match_cnt_d = '0;
            miss_cnt_d  = '0;
          end
        end
        ST_ACQUIRE: begin
          if (edge_c) begin
            if (match_c) begin
              match_cnt_d = match_cnt_q + MC_W'(1);
              if (match_cnt_d == MC_W'(LOCK_FRAMES)) begin
                state_d    = ST_LOCKED;
                miss_cnt_d = '0;
              end
            end else begin
              ref_d       = cnt_q;
              match_cnt_d = '0;
            end
          end else if (timeout_c) begin
            state_d     = ST_SEARCH;
            match_cnt_d = '0;
            miss_cnt_d  = '0;
          end
        end
        ST_LOCKED: begin
          if (edge_c) begin
            if (match_c) begin
              ref_d      = cnt_q;
              miss_cnt_d = '0;
            end else begin
              miss_cnt_d = miss_cnt_q + MS_W'(1);
              if (miss_cnt_d == MS_W'(UNLOCK_MISSES)) begin
                state_d     = ST_SEARCH;
                match_cnt_d = '0;
                miss_cnt_d  = '0;
              end
            end
          end else if (timeout_c) begin
            state_d     = ST_SEARCH;
            match_cnt_d = '0;
            miss_cnt_d  = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    locked_d = (state_d == ST_LOCKED);
    period_d = locked_d ? ref_d : '0;
    strobe_d = bus.enable_in && edge_c &&
               ((state_q == ST_LOCKED) || (state_d == ST_LOCKED));
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk_in) begin
    if (!resetb) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ref_q       <= '0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      locked_q    <= 1'b0;
      period_q    <= '0;
      strobe_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ref_q       <= ref_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      locked_q    <= locked_d;
      period_q    <= period_d;
      strobe_q    <= strobe_d;
    end
  end

  assign bus.audio_locked_out = locked_q;
  assign bus.period_out       = period_q;
  assign bus.frame_strobe_out = strobe_q;

endmodule

// File: tb/tb_audio_lock_detect.sv
// Self-checking bench for audio_lock_detect: directed table, corner sequences
// and randomized frames, all compared against a behavioural model.
module tb_audio_lock_detect;

  localparam int unsigned CNT_W   = 12;
  localparam int          TIMEOUT = 4095;
  localparam int          MINP    = 16;
  localparam int          TOLV    = 2;
  localparam int          LOCKN   = 8;
  localparam int          MISSN   = 2;

  logic clk_in = 1'b0;
  logic resetb;
  always #5 clk_in = ~clk_in;

  audio_lock_detect_if #(.CNT_W(CNT_W)) bus ();

  audio_lock_detect #(
    .CNT_W(CNT_W), .MIN_PERIOD(16), .TOL(2), .LOCK_FRAMES(8), .UNLOCK_MISSES(2)
  ) dut (
    .clk_in (clk_in),
    .resetb (resetb),
    .bus    (bus)
  );

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  // Behavioural model: modes are 0 idle, 1 search, 2 prime, 3 acquire, 4 locked.
  int     m_mode = 0, m_ref = 0, m_match = 0, m_miss = 0;
  longint cyc = 0, m_last = 0;
  bit     h0 = 0, h1 = 0, h2 = 0;
  bit     exp_locked = 0, exp_strobe = 0;
  int     exp_period = 0;

  function automatic bit good(int meas, int rf);
    int d;
    d = meas - rf;
    if (d < 0) d = -d;
    return (meas >= MINP) && (meas < TIMEOUT) && (d <= TOLV);
  endfunction

  always @(posedge clk_in) begin
    bit     e, tmo;
    int     prev, meas;
    longint since;
    cyc = cyc + 1;
    e   = h1 & ~h2;
    h2  = h1; h1 = h0; h0 = bus.ws_in;
    if (!resetb) begin
      m_mode = 0; m_ref = 0; m_match = 0; m_miss = 0;
      h0 = 0; h1 = 0; h2 = 0; m_last = cyc;
      exp_locked = 0; exp_period = 0; exp_strobe = 0;
    end else begin
      since = cyc - m_last;
      meas  = (since > TIMEOUT) ? TIMEOUT : int'(since);
      tmo   = (since >= TIMEOUT);
      prev  = m_mode;
      if (!bus.enable_in) begin
        m_mode = 0; m_ref = 0; m_match = 0; m_miss = 0;
      end else begin
        case (m_mode)
          0: m_mode = 1;
          1: if (e) m_mode = 2;
          2: if (e) begin m_ref = meas; m_match = 0; m_mode = 3; end
             else if (tmo) begin m_mode = 1; m_match = 0; m_miss = 0; end
          3: if (e) begin
               if (good(meas, m_ref)) begin
                 m_match++;
                 if (m_match == LOCKN) begin m_mode = 4; m_miss = 0; end
               end else begin
                 m_ref = meas; m_match = 0;
               end
             end else if (tmo) begin m_mode = 1; m_match = 0; m_miss = 0; end
          4: if (e) begin
               if (good(meas, m_ref)) begin m_ref = meas; m_miss = 0; end
               else begin
                 m_miss++;
                 if (m_miss == MISSN) begin m_mode = 1; m_miss = 0; m_match = 0; end
               end
             end else if (tmo) begin m_mode = 1; m_match = 0; m_miss = 0; end
          default: m_mode = 0;
        endcase
        if (e) m_last = cyc;
      end
      exp_locked = (m_mode == 4);
      exp_period = exp_locked ? m_ref : 0;
      exp_strobe = bus.enable_in && e && (prev == 4 || m_mode == 4);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, req);
    end
  endtask

  // One clock: check outputs of the previous edge, then drive this cycle's inputs.
  task automatic step(input logic ws, input logic en, input logic rb);
    @(negedge clk_in);
    if (chk_on) begin
      chk("locked", 32'(bus.audio_locked_out), 32'(exp_locked));
      chk("period", 32'(bus.period_out), 32'(exp_period));
      chk("strobe", 32'(bus.frame_strobe_out), 32'(exp_strobe));
    end
    bus.ws_in     = ws;
    bus.enable_in = en;
    resetb        = rb;
  endtask

  task automatic frame(input int period, input logic en, input logic rb);
    for (int i = 0; i < period; i++) step(i < period / 2, en, rb);
  endtask

  typedef struct {
    int period;
    int frames;
    bit en;
    bit rb;
    bit exp_locked;
    int exp_period;
  } vec_t;

  vec_t tbl [39];

  initial begin
    int  fall_at;
    bit  fell;
    int  per, r;
    bit  en;

    tbl = '{
      '{64, 9, 1, 1, 0, 0},   '{64, 1, 1, 1, 1, 64},  '{63, 1, 1, 1, 1, 64},
      '{65, 1, 1, 1, 1, 63},  '{63, 1, 1, 1, 1, 65},  '{80, 1, 1, 1, 1, 63},
      '{64, 1, 1, 1, 1, 63},  '{80, 1, 1, 1, 1, 64},  '{80, 1, 1, 1, 1, 64},
      '{64, 1, 1, 1, 0, 0},   '{64, 10, 1, 1, 1, 64}, '{64, 1, 0, 1, 0, 0},
      '{64, 5, 1, 1, 0, 0},   '{70, 1, 1, 1, 0, 0},   '{64, 1, 1, 1, 0, 0},
      '{64, 8, 1, 1, 0, 0},   '{64, 1, 1, 1, 1, 64},  '{0, 4200, 1, 1, 0, 0},
      '{64, 10, 1, 1, 1, 64}, '{64, 1, 1, 0, 0, 0},   '{64, 10, 1, 1, 1, 64},
      '{64, 1, 0, 1, 0, 0},   '{64, 5, 1, 1, 0, 0},   '{64, 1, 0, 1, 0, 0},
      '{64, 5, 1, 1, 0, 0},   '{64, 1, 1, 0, 0, 0},   '{64, 9, 1, 1, 0, 0},
      '{64, 1, 1, 1, 1, 64},  '{4095, 1, 1, 1, 1, 64}, '{64, 1, 1, 1, 1, 64},
      '{66, 1, 1, 1, 1, 64},  '{64, 1, 1, 1, 1, 66},  '{67, 1, 1, 1, 1, 64},
      '{64, 1, 1, 1, 1, 64},  '{64, 1, 1, 1, 1, 64},  '{16, 1, 0, 1, 0, 0},
      '{16, 10, 1, 1, 1, 16}, '{15, 1, 0, 1, 0, 0},   '{15, 12, 1, 1, 0, 0}
    };

    resetb        = 1'b0;
    bus.enable_in = 1'b0;
    bus.ws_in     = 1'b0;

    // Reset held with ws toggling and enable high: outputs must stay 0.
    step(1'b0, 1'b1, 1'b0);
    chk_on = 1'b1;
    for (int i = 0; i < 5; i++) step(i[0], 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("reset_locked", 32'(bus.audio_locked_out), 32'd0);
    chk("reset_period", 32'(bus.period_out), 32'd0);

    // Directed table; a zero period means hold ws low to force a timeout.
    for (int i = 0; i < 39; i++) begin
      if (tbl[i].period == 0) begin
        fell    = 1'b0;
        fall_at = -1;
        for (int h = 0; h < tbl[i].frames; h++) begin
          step(1'b0, tbl[i].en, tbl[i].rb);
          if (!fell && bus.audio_locked_out === 1'b0) begin
            fell    = 1'b1;
            fall_at = h;
          end
        end
        // Last edge was seen 2 cycles into the preceding 64-cycle frame.
        chk("timeout_fall_cycle", 32'(fall_at), 32'd4034);
      end else begin
        for (int f = 0; f < tbl[i].frames; f++) frame(tbl[i].period, tbl[i].en, tbl[i].rb);
      end
      chk($sformatf("vec%0d_locked", i), 32'(bus.audio_locked_out), 32'(tbl[i].exp_locked));
      chk($sformatf("vec%0d_period", i), 32'(bus.period_out), 32'(tbl[i].exp_period));
    end

    // Randomized frames around the nominal rate with occasional outliers and aborts.
    for (int n = 0; n < 200; n++) begin
      r   = int'($urandom_range(0, 99));
      en  = 1'b1;
      per = 62 + int'($urandom_range(0, 4));
      if (r < 5)       per = 100;
      else if (r < 10) per = 14 + int'($urandom_range(0, 4));
      else if (r < 12) en  = 1'b0;
      if (r == 12) frame(per, 1'b1, 1'b0);
      else         frame(per, en, 1'b1);
    end

    step(1'b0, 1'b1, 1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/audio_lock_detect.md
AUDIO_LOCK_DETECT -- requirements
Module: audio_lock_detect

Interface
REQ-001 SHALL have parameter CNT_W, default 12, width of the period counter and period_out.
REQ-002 SHALL have parameter MIN_PERIOD, default 16, smallest valid frame period in clk_in cycles.
REQ-003 SHALL have parameter TOL, default 2, maximum allowed |measured - reference| in cycles for a match.
REQ-004 SHALL have parameter LOCK_FRAMES, default 8, number of consecutive matches needed to lock.
REQ-005 SHALL have parameter UNLOCK_MISSES, default 2, number of consecutive mismatches needed to drop lock.
REQ-006 SHALL have port clk_in  input  1  system clock.
REQ-007 SHALL have port resetb  input  1  synchronous, active-low reset.
REQ-008 SHALL have port enable_in  input  1  detector enable, synchronous to clk_in.
REQ-009 SHALL have port ws_in  input  1  I2S word-select, asynchronous to clk_in.
REQ-010 SHALL have port audio_locked_out  output  1  stable frame rate detected; drives the amplifier controller's audio_locked_in.
REQ-011 SHALL have port period_out  output  CNT_W  current reference frame period in clk_in cycles.
REQ-012 SHALL have port frame_strobe_out  output  1  one-cycle pulse per ws rising edge while locked.

Function
REQ-013 SHALL pass ws_in through a two-flop synchronizer plus one edge flop; rising edge = sync2 & ~edge_ff.
REQ-014 SHALL run the period counter cnt: load 1 on the edge cycle, otherwise increment and saturate at 2^CNT_W-1 (TIMEOUT).
REQ-015 SHALL take measured = cnt on an edge cycle, which equals the cycle count since the previous edge.
REQ-016 SHALL define match as measured >= MIN_PERIOD, measured < TIMEOUT and |measured - ref| <= TOL, using CNT_W+1-bit signed arithmetic.
REQ-017 SHALL implement states IDLE, SEARCH, PRIME, ACQUIRE and LOCKED.
REQ-018 IDLE: on enable_in=1, go to SEARCH.
REQ-019 SEARCH: on the first edge, go to PRIME; the counter starts at that edge.
REQ-020 PRIME: on an edge, set ref = measured, set match_cnt = 0 and go to ACQUIRE.
REQ-021 ACQUIRE: on a matching edge, increment match_cnt, keep ref unchanged, and go to LOCKED when match_cnt reaches LOCK_FRAMES.
REQ-022 ACQUIRE: on a mismatching edge, set ref = measured and match_cnt = 0, and stay in ACQUIRE.
REQ-023 LOCKED: on a matching edge, set ref = measured (tracking) and miss_cnt = 0.
REQ-024 LOCKED: on a mismatching edge, keep ref and increment miss_cnt; when miss_cnt reaches UNLOCK_MISSES, go to SEARCH.
REQ-025 SHALL go to SEARCH from PRIME, ACQUIRE or LOCKED when cnt reaches TIMEOUT with no edge, and clear match_cnt and miss_cnt.
REQ-026 If an edge and cnt = TIMEOUT occur in the same cycle, SHALL process the edge as a mismatch.
REQ-027 SHALL go to IDLE from any state on the next cycle when enable_in=0, clearing ref, counters and outputs; enable has priority over edge and timeout.
REQ-028 SHALL register audio_locked_out high exactly while state = LOCKED; it rises the cycle after the lock-qualifying edge is detected.
REQ-029 SHALL register period_out = ref while LOCKED, and 0 otherwise.
REQ-030 SHALL register frame_strobe_out to pulse for one cycle for each edge processed in LOCKED, including the lock-qualifying edge.

Reset
REQ-031 SHALL, with resetb=0 at a clk_in edge, clear state to IDLE and clear cnt, ref, match_cnt, miss_cnt and the synchronizer flops; all outputs SHALL be 0 on the following cycle.
REQ-032 SHALL abandon acquisition or lock on reset mid-operation, with no residual ref or counts.
REQ-033 SHALL require, after reset release, a full SEARCH/PRIME/ACQUIRE sequence before audio_locked_out can assert.

Verification
REQ-034 Reset: hold resetb=0 for 5 cycles with ws toggling -> audio_locked_out=0, period_out=0, frame_strobe_out=0.
REQ-035 Lock: enable_in=1, ws period 64 cycles -> audio_locked_out rises 1 cycle after the 10th detected rising edge (SEARCH 1, PRIME 1, 8 matches) and period_out=64.
REQ-036 Jitter: periods alternating 63/65 while locked -> stays locked, period_out follows 63/65, one strobe per frame; a single 70-cycle period in ACQUIRE -> match_cnt restarts and lock is delayed 8 more frames.
REQ-037 Miss: one 80-cycle period while locked -> stays locked, miss_cnt=1; two consecutive 80-cycle periods -> audio_locked_out falls 1 cycle after the second edge.
REQ-038 Timeout: ws held constant while locked -> audio_locked_out falls when cnt reaches 4095; ws restart at 64 -> relocks after 10 edges.
REQ-039 Abort: enable_in=0, or resetb=0, during LOCKED and during ACQUIRE -> all outputs 0 the next cycle; re-enable -> full reacquisition.
